// File: rtl/psum_accum_buffer.sv
// psum_accum_buffer: accumulates adder-tree partial sums across passes,
// then drains them requantised through a valid/ready stream.
module psum_accum_buffer #(
    parameter int LANES   = 4,
    parameter int PSUM_W  = 41,
    parameter int OUT_W   = 16,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int PASS_W  = 8,
    parameter int SHIFT_W = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W:0]         num_pos,
    input  logic [PASS_W-1:0]       num_pass,
    input  logic [SHIFT_W-1:0]      shift,
    input  logic                    in_valid,
    input  logic [LANES*PSUM_W-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*OUT_W-1:0]  out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    drop_err,
    output logic                    sat_err
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    localparam logic signed [PSUM_W-1:0] ACC_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] ACC_MIN = {1'b1, {(PSUM_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [PSUM_W:0] ONE = 1;

    state_t               state;
    logic [ADDR_W-1:0]    cfg_last;
    logic [PASS_W-1:0]    cfg_pass_last;
    logic [SHIFT_W-1:0]   cfg_shift;
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [PASS_W-1:0]    pass_cnt;

    logic signed [PSUM_W-1:0] acc [DEPTH][LANES];
    logic signed [PSUM_W-1:0] acc_nxt [LANES];
    logic signed [PSUM_W-1:0] add_a [LANES];
    logic signed [PSUM_W-1:0] add_b [LANES];
    logic signed [PSUM_W:0]   add_s [LANES];
    logic signed [PSUM_W:0]   rq_ext [LANES];
    logic signed [PSUM_W:0]   rq_sum [LANES];
    logic signed [PSUM_W:0]   rq_sh  [LANES];
    logic [LANES-1:0]         add_ovf;
    logic [LANES-1:0]         clamp;
    logic [LANES*OUT_W-1:0]   rq_data;
    logic [ADDR_W:0]          pos_n;
    logic                     beat;
    logic                     hs;
    logic                     first_pass;

    assign beat       = (state == ACCUM) && in_valid;
    assign hs         = (state == DRAIN) && out_ready;
    assign first_pass = (pass_cnt == '0);

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DRAIN);
    assign busy      = (state != IDLE);
    assign out_data  = out_valid ? rq_data : '0;
    assign out_last  = out_valid && (rd_ptr == cfg_last);

    // Effective position count: zero means one, oversize clamps to DEPTH.
    always_comb begin
        pos_n = num_pos;
        if (num_pos == '0)
            pos_n = 1;
        else if (num_pos > (ADDR_W+1)'(DEPTH))
            pos_n = (ADDR_W+1)'(DEPTH);
    end

    // Per-lane saturating accumulate, overwrite on the first pass.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            add_a[k]   = acc[wr_ptr][k];
            add_b[k]   = in_data[k*PSUM_W +: PSUM_W];
            add_s[k]   = {add_a[k][PSUM_W-1], add_a[k]}
                       + {add_b[k][PSUM_W-1], add_b[k]};
            add_ovf[k] = !first_pass
                       && (add_s[k][PSUM_W] != add_s[k][PSUM_W-1]);
            if (first_pass)
                acc_nxt[k] = add_b[k];
            else if (add_ovf[k])
                acc_nxt[k] = add_s[k][PSUM_W] ? ACC_MIN : ACC_MAX;
            else
                acc_nxt[k] = add_s[k][PSUM_W-1:0];
        end
    end

    // Round-half-up, arithmetic shift, then clamp to the output width.
    always_comb begin
        rq_data = '0;
        for (int k = 0; k < LANES; k++) begin
            rq_ext[k] = {acc[rd_ptr][k][PSUM_W-1], acc[rd_ptr][k]};
            if (cfg_shift == '0)
                rq_sum[k] = rq_ext[k];
            else
                rq_sum[k] = rq_ext[k] + (ONE <<< (cfg_shift - 1'b1));
            rq_sh[k] = rq_sum[k] >>> cfg_shift;
            clamp[k] = !((&rq_sh[k][PSUM_W:OUT_W-1])
                      || (~|rq_sh[k][PSUM_W:OUT_W-1]));
            if (clamp[k])
                rq_data[k*OUT_W +: OUT_W] = rq_sh[k][PSUM_W] ? OUT_MIN : OUT_MAX;
            else
                rq_data[k*OUT_W +: OUT_W] = rq_sh[k][OUT_W-1:0];
        end
    end

    // Accumulator file; contents need no reset.
    always_ff @(posedge clk) begin
        if (beat) begin
            for (int k = 0; k < LANES; k++)
                acc[wr_ptr][k] <= acc_nxt[k];
        end
    end

    // Tile sequencing, pointers and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cfg_last      <= '0;
            cfg_pass_last <= '0;
            cfg_shift     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pass_cnt      <= '0;
            done          <= 1'b0;
            drop_err      <= 1'b0;
            sat_err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_valid && (state != ACCUM))
                drop_err <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cfg_last      <= ADDR_W'(pos_n - 1'b1);
                        cfg_pass_last <= (num_pass == '0) ? '0 : num_pass - 1'b1;
                        cfg_shift     <= shift;
                        wr_ptr        <= '0;
                        rd_ptr        <= '0;
                        pass_cnt      <= '0;
                        drop_err      <= 1'b0;
                        sat_err       <= 1'b0;
                        state         <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        if (|add_ovf)
                            sat_err <= 1'b1;
                        if (wr_ptr == cfg_last) begin
                            wr_ptr <= '0;
                            if (pass_cnt == cfg_pass_last) begin
                                rd_ptr <= '0;
                                state  <= DRAIN;
                            end else begin
                                pass_cnt <= pass_cnt + 1'b1;
                            end
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        if (|clamp)
                            sat_err <= 1'b1;
                        if (rd_ptr == cfg_last) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum_buffer.sv
// tb_psum_accum_buffer: scoreboard bench for psum_accum_buffer.
// Expected words come from a longint reference model of accumulate/requant.
module tb_psum_accum_buffer;

    localparam int LANES  = 4;
    localparam int PSUM_W = 41;
    localparam int OUT_W  = 16;
    localparam longint MAXA = 64'sd1099511627775;
    localparam longint MINA = -64'sd1099511627776;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic [4:0]              num_pos;
    logic [7:0]              num_pass;
    logic [5:0]              shift;
    logic                    in_valid;
    logic [LANES*PSUM_W-1:0] in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*OUT_W-1:0]  out_data;
    logic                    out_last;
    logic                    busy;
    logic                    done;
    logic                    drop_err;
    logic                    sat_err;

    always #5 clk = ~clk;

    psum_accum_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_pos   (num_pos),
        .num_pass  (num_pass),
        .shift     (shift),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .drop_err  (drop_err),
        .sat_err   (sat_err)
    );

    typedef struct {
        logic [63:0] data;
        bit          last;
    } word_t;

    int     checks = 0;
    int     errors = 0;
    word_t  sb[$];
    longint beat_q[$];
    longint macc [16][4];
    bit     exp_sat;
    bit     bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic longint sat_acc(input longint s);
        if (s > MAXA) return MAXA;
        if (s < MINA) return MINA;
        return s;
    endfunction

    function automatic longint requant(input longint v, input int sh,
                                       output bit c);
        longint r;
        r = v;
        if (sh > 0)
            r = (v + (64'sd1 <<< (sh - 1))) >>> sh;
        c = 1'b0;
        if (r > 32767) begin
            r = 32767;
            c = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            c = 1'b1;
        end
        return r;
    endfunction

    task automatic push_beat(input longint a, input longint b,
                             input longint c, input longint d);
        beat_q.push_back(a);
        beat_q.push_back(b);
        beat_q.push_back(c);
        beat_q.push_back(d);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_out_last"},  out_last,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_drop_err"},  drop_err,  0);
        check({tag, "_sat_err"},   sat_err,   0);
    endtask

    task automatic accumulate(input int pos, input int pass, input int sh);
        longint v;
        longint s;
        longint r;
        bit     c;
        word_t  w;
        @(negedge clk);
        num_pos  = 5'(pos);
        num_pass = 8'(pass);
        shift    = 6'(sh);
        start    = 1'b1;
        exp_sat  = 1'b0;
        for (int p = 0; p < pass; p++) begin
            for (int i = 0; i < pos; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (p == 0 && i == 0) begin
                    check("in_ready", in_ready, 1);
                    check("drop_clr", drop_err, 0);
                    check("sat_clr", sat_err, 0);
                end
                for (int k = 0; k < LANES; k++) begin
                    v = beat_q.pop_front();
                    in_data[k*PSUM_W +: PSUM_W] = v[PSUM_W-1:0];
                    if (p == 0) begin
                        macc[i][k] = v;
                    end else begin
                        s = macc[i][k] + v;
                        if (s > MAXA || s < MINA)
                            exp_sat = 1'b1;
                        macc[i][k] = sat_acc(s);
                    end
                end
                in_valid = 1'b1;
            end
        end
        for (int i = 0; i < pos; i++) begin
            w.data = '0;
            for (int k = 0; k < LANES; k++) begin
                r = requant(macc[i][k], sh, c);
                if (c)
                    exp_sat = 1'b1;
                w.data[k*OUT_W +: OUT_W] = r[OUT_W-1:0];
            end
            w.last = (i == pos - 1);
            sb.push_back(w);
        end
    endtask

    task automatic drain(input bit bp);
        int          n;
        int          got;
        int          cyc;
        bit          rdy;
        bit          stalled;
        logic [63:0] held;
        word_t       w;
        n       = sb.size();
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            in_valid  = 1'b0;
            rdy       = bp ? bp_pat[(cyc - 1) % 4] : 1'b1;
            out_ready = rdy;
            start     = 1'b0;
            if (cyc == 1)
                check("latency", out_valid, 1);
            if (stalled)
                check("stable", out_data, held);
            stalled = 1'b0;
            if (out_valid && rdy) begin
                w = sb.pop_front();
                check("data", out_data, w.data);
                check("last", out_last, w.last);
                got++;
            end else if (out_valid) begin
                stalled = 1'b1;
                held    = out_data;
            end
            if (bp && got < n)
                start = 1'b1;
        end
        if (got < n)
            check("drain_timeout", 64'(got), 64'(n));
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("valid_end", out_valid, 0);
        check("sat_err", sat_err, exp_sat);
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        num_pos   = '0;
        num_pass  = '0;
        shift     = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;

        for (int i = 1; i <= 4; i++)
            push_beat(10 * i, -i, 0, 7);
        accumulate(4, 1, 0);
        drain(1'b0);

        for (int i = 0; i < 6; i++)
            push_beat(5, 5, 5, 5);
        accumulate(2, 3, 2);
        drain(1'b0);

        for (int i = 0; i < 4; i++)
            push_beat(-7, 1, 0, -1);
        accumulate(1, 4, 0);
        drain(1'b0);

        push_beat(100000, -100000, 3, -3);
        accumulate(1, 1, 0);
        drain(1'b0);

        push_beat(MAXA, MINA, 5, -5);
        push_beat(MAXA, MINA, 5, -5);
        accumulate(1, 2, 30);
        drain(1'b0);

        for (int i = 0; i < 24; i++)
            beat_q.push_back(longint'($urandom_range(0, 2000)) - 1000);
        accumulate(3, 2, 1);
        drain(1'b1);

        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("drop_err", drop_err, 1);

        push_beat(1, 2, 3, 4);
        push_beat(5, 6, 7, 8);
        accumulate(2, 1, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("drain_entered", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            beat_q.push_back(longint'($urandom_range(0, 200000)) - 100000);
        accumulate(2, 2, 3);
        drain(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
